// File: rtl/mdc_output_commutator_if.sv
// Dual-path input / serial output bundle of the MDC FFT output commutator.
// The slave modport is the commutator's view; the master modport is the pipeline/consumer side.
interface mdc_output_commutator_if #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned N     = 32
);
    localparam int unsigned IW = $clog2(N);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] inUP_re;
    logic signed [WIDTH-1:0] inUP_im;
    logic signed [WIDTH-1:0] inLO_re;
    logic signed [WIDTH-1:0] inLO_im;

    logic                    out_valid;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [IW-1:0]           out_index;
    logic                    out_last;

    modport slave (
        input  in_valid,
        input  inUP_re,
        input  inUP_im,
        input  inLO_re,
        input  inLO_im,
        output in_ready,
        output out_valid,
        output out_re,
        output out_im,
        output out_index,
        output out_last
    );

    modport master (
        output in_valid,
        output inUP_re,
        output inUP_im,
        output inLO_re,
        output inLO_im,
        input  in_ready,
        input  out_valid,
        input  out_re,
        input  out_im,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/mdc_output_commutator.sv
// Output commutator of the MDC FFT: emits each frame's upper-path samples as they arrive,
// buffering the lower-path samples and draining them afterwards as the second half of the frame.
module mdc_output_commutator #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned N     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    mdc_output_commutator_if.slave   bus
);
    localparam int unsigned HALF = N / 2;
    localparam int unsigned CW   = $clog2(HALF);
    localparam int unsigned IW   = $clog2(N);
    localparam int unsigned BW   = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);

    typedef enum logic {
        S_PASS  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic signed [WIDTH-1:0] r_out_re;
    logic signed [WIDTH-1:0] r_out_im;
    logic [IW-1:0]           r_out_index;
    logic [BW-1:0]           r_buf [HALF];

    state_t                  w_state_nxt;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_valid_nxt;
    logic                    w_last_nxt;
    logic signed [WIDTH-1:0] w_re_nxt;
    logic signed [WIDTH-1:0] w_im_nxt;
    logic [IW-1:0]           w_idx_nxt;
    logic                    w_accept;
    logic [BW-1:0]           w_rd_word;
    logic signed [WIDTH-1:0] w_rd_re;
    logic signed [WIDTH-1:0] w_rd_im;

    assign bus.in_ready  = (r_state == S_PASS);
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_re    = r_out_re;
    assign bus.out_im    = r_out_im;
    assign bus.out_index = r_out_index;

    assign w_accept  = bus.in_valid && (r_state == S_PASS);
    assign w_rd_word = r_buf[r_cnt];
    assign w_rd_re   = w_rd_word[BW-1:WIDTH];
    assign w_rd_im   = w_rd_word[WIDTH-1:0];

    // Next-state and output decode; idle PASS cycles hold data/index and drop valid/last.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_re_nxt    = r_out_re;
        w_im_nxt    = r_out_im;
        w_idx_nxt   = r_out_index;

        case (r_state)
            S_PASS: begin
                if (w_accept) begin
                    w_re_nxt    = bus.inUP_re;
                    w_im_nxt    = bus.inUP_im;
                    w_idx_nxt   = {1'b0, r_cnt};
                    w_valid_nxt = 1'b1;
                    if (r_cnt == CNT_MAX) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                w_re_nxt    = w_rd_re;
                w_im_nxt    = w_rd_im;
                w_idx_nxt   = {1'b1, r_cnt};
                w_valid_nxt = 1'b1;
                if (r_cnt == CNT_MAX) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = S_PASS;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_PASS;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PASS;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_index <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_out_re    <= w_re_nxt;
            r_out_im    <= w_im_nxt;
            r_out_index <= w_idx_nxt;
        end
    end

    // Lower-path buffer: written only while passing, read only while draining, never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_cnt] <= {bus.inLO_re, bus.inLO_im};
        end
    end
endmodule

// File: tb/tb_mdc_output_commutator.sv
// Directed bench for mdc_output_commutator: back-to-back, gapped, chained, extreme-value
// and reset scenarios with hand-derived expected output sequences.
module tb_mdc_output_commutator;
    localparam int W    = 9;
    localparam int N    = 32;
    localparam int HALF = N / 2;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    bit   ext   = 1'b0;

    mdc_output_commutator_if #(.WIDTH(W), .N(N)) bus ();

    mdc_output_commutator #(.WIDTH(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected sample at frame position idx: base+idx / -(base+idx), or alternating extremes.
    function automatic int val_re(input int base, input int idx);
        if (ext) return (idx % 2 == 1) ? 255 : -256;
        return base + idx;
    endfunction

    function automatic int val_im(input int base, input int idx);
        if (ext) return (idx % 2 == 1) ? -256 : 255;
        return -(base + idx);
    endfunction

    task automatic chk(input string tag, input int at,
                       input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @%0d: observed %0d, expected %0d", tag, at, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int base, input int k);
        bus.in_valid = 1'b1;
        bus.inUP_re  = W'(val_re(base, k));
        bus.inUP_im  = W'(val_im(base, k));
        bus.inLO_re  = W'(val_re(base, HALF + k));
        bus.inLO_im  = W'(val_im(base, HALF + k));
    endtask

    task automatic drive_junk(input int d);
        bus.in_valid = 1'b1;
        bus.inUP_re  = W'(200 - d);
        bus.inUP_im  = W'(200 - d);
        bus.inLO_re  = W'(190 - d);
        bus.inLO_im  = W'(190 - d);
    endtask

    task automatic check_out(input int at, input bit v, input int re, input int im,
                             input int idx, input bit last, input bit rdy);
        chk("out_valid", at, bus.out_valid, v);
        if (v) begin
            chk("out_re", at, bus.out_re, re);
            chk("out_im", at, bus.out_im, im);
            chk("out_index", at, bus.out_index, idx);
        end
        chk("out_last", at, bus.out_last, last);
        chk("in_ready", at, bus.in_ready, rdy);
    endtask

    task automatic check_reset(input int at);
        chk("rst_valid", at, bus.out_valid, 0);
        chk("rst_last", at, bus.out_last, 0);
        chk("rst_re", at, bus.out_re, 0);
        chk("rst_im", at, bus.out_im, 0);
        chk("rst_index", at, bus.out_index, 0);
        chk("rst_ready", at, bus.in_ready, 1);
    endtask

    // One frame: upper beats (with an optional idle gap after beat gap_after), then the drain.
    task automatic run_frame(input int base, input int gap_after, input int gap_len, input bit junk);
        for (int s = 0; s < HALF + gap_len; s++) begin
            bit is_gap;
            int k;
            is_gap = (s > gap_after) && (s <= gap_after + gap_len);
            k      = (s > gap_after + gap_len) ? s - gap_len : s;
            if (is_gap) bus.in_valid = 1'b0;
            else        drive_beat(base, k);
            tick();
            if (is_gap) check_out(base + s, 1'b0, 0, 0, 0, 1'b0, 1'b1);
            else        check_out(base + s, 1'b1, val_re(base, k), val_im(base, k), k,
                                  1'b0, k != HALF - 1);
        end
        for (int d = 0; d < HALF; d++) begin
            if (junk) drive_junk(d);
            else      bus.in_valid = 1'b0;
            tick();
            check_out(base + 100 + d, 1'b1, val_re(base, HALF + d), val_im(base, HALF + d),
                      HALF + d, d == HALF - 1, d == HALF - 1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_idle(input int at);
        tick();
        check_out(at, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.inUP_re  = '0;
        bus.inUP_im  = '0;
        bus.inLO_re  = '0;
        bus.inLO_im  = '0;

        // Asynchronous reset before the first clock edge.
        #3 rst = 1'b1;
        #1 check_reset(0);
        tick();
        tick();
        check_reset(1);
        rst = 1'b0;

        // Back-to-back frame: out_re = out_index = 0..31.
        run_frame(0, HALF, 0, 1'b0);
        check_idle(1000);

        // Three idle cycles after beat 5.
        run_frame(0, 5, 3, 1'b0);
        check_idle(2000);

        // Junk held valid through the drain, then a second frame chained with no gap.
        run_frame(20, HALF, 0, 1'b1);
        run_frame(100, HALF, 0, 1'b0);
        check_idle(3000);

        // Full-scale values on every component.
        ext = 1'b1;
        run_frame(0, HALF, 0, 1'b0);
        ext = 1'b0;
        check_idle(4000);

        // Reset pulsed between edges after beat 7 of a partial frame.
        for (int k = 0; k < 8; k++) begin
            drive_beat(60, k);
            tick();
            check_out(5000 + k, 1'b1, val_re(60, k), val_im(60, k), k, 1'b0, 1'b1);
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset(5100);
        tick();
        check_reset(5101);
        rst = 1'b0;
        run_frame(50, HALF, 0, 1'b0);
        check_idle(6000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
